score_ctrl: RTL and testbench

- Game-state and score controller for the FlappyBird datapath.
- Sequences the WAIT / PLAY / OVER game phases from the start button, pipe-pass and collision events.
- Keeps the running score and the session best score in binary, and drives the waiting/over/score inputs of the seven-segment display block.
- Generates a divided digit-scan enable so the display scan runs at a visible refresh rate instead of the raw pixel clock.

---
 rtl/score_ctrl.sv | 169 ++++++++++++++++
 tb/tb_score_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: game-phase sequencer, score/best keeper and display scan strobe
// for the FlappyBird datapath. Everything runs on the rising edge of vga_clk.
module score_ctrl #(
  parameter int SCORE_MAX   = 999,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCAN_DIV    = 25000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pass_pulse,
  input  logic        collide,
  output logic        waiting,
  output logic        playing,
  output logic        over,
  output logic        game_rst,
  output logic [11:0] score,
  output logic [11:0] best,
  output logic        new_best,
  output logic        scan_en
);

  // Hold counter only ever holds values up to HOLD_CYCLES-1.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 32'sd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(32'd0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 32'sd1);
  localparam logic [SCAN_W-1:0] SCAN_ZERO = SCAN_W'(32'd0);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(32'd1);
  localparam logic [11:0]       SCORE_LIM = 12'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                btn_q_r;
  logic                rise_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_nxt_s;
  logic [SCAN_W-1:0]   scan_cnt_r;
  logic [SCAN_W-1:0]   scan_cnt_nxt_s;
  logic                scan_wrap_s;
  logic [11:0]         score_r;
  logic [11:0]         score_nxt_s;
  logic [11:0]         best_r;
  logic [11:0]         best_nxt_s;
  logic                new_best_r;
  logic                new_best_nxt_s;
  logic                game_rst_r;
  logic                game_rst_nxt_s;
  logic                waiting_r;
  logic                playing_r;
  logic                over_r;
  logic                scan_en_r;

  assign rise_s      = start_btn & ~btn_q_r;
  assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);

  assign waiting  = waiting_r;
  assign playing  = playing_r;
  assign over     = over_r;
  assign game_rst = game_rst_r;
  assign score    = score_r;
  assign best     = best_r;
  assign new_best = new_best_r;
  assign scan_en  = scan_en_r;

  // Next game phase, score, best and OVER dwell counter.
  always_comb begin
    state_nxt_s    = state_r;
    score_nxt_s    = score_r;
    best_nxt_s     = best_r;
    new_best_nxt_s = new_best_r;
    hold_nxt_s     = hold_r;
    game_rst_nxt_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (rise_s) begin
          state_nxt_s    = ST_PLAY;
          score_nxt_s    = 12'd0;
          game_rst_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = ST_WAIT;
        end
      end
      ST_PLAY: begin
        // Collision wins over a same-cycle pass; best compares the pre-update score.
        if (collide) begin
          state_nxt_s = ST_OVER;
          hold_nxt_s  = HOLD_LOAD;
          if (score_r > best_r) begin
            best_nxt_s     = score_r;
            new_best_nxt_s = 1'b1;
          end else begin
            best_nxt_s     = best_r;
          end
        end else if (pass_pulse && (score_r < SCORE_LIM)) begin
          score_nxt_s = score_r + 12'd1;
        end else begin
          score_nxt_s = score_r;
        end
      end
      ST_OVER: begin
        // A press during the dwell is dropped, not queued.
        if (hold_r != HOLD_ZERO) begin
          hold_nxt_s = hold_r - HOLD_ONE;
        end else if (rise_s) begin
          state_nxt_s    = ST_WAIT;
          new_best_nxt_s = 1'b0;
        end else begin
          hold_nxt_s     = HOLD_ZERO;
        end
      end
      default: begin
        state_nxt_s    = ST_WAIT;
        new_best_nxt_s = 1'b0;
      end
    endcase
  end

  // Free-running scan divider, wraps after SCAN_DIV-1.
  always_comb begin
    scan_cnt_nxt_s = scan_cnt_r + SCAN_ONE;
    if (scan_wrap_s) begin
      scan_cnt_nxt_s = SCAN_ZERO;
    end else begin
      scan_cnt_nxt_s = scan_cnt_r + SCAN_ONE;
    end
  end

  // State, datapath and registered outputs; btn_q resets high so a held button cannot start a game.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_r    <= ST_WAIT;
      btn_q_r    <= 1'b1;
      hold_r     <= HOLD_ZERO;
      scan_cnt_r <= SCAN_ZERO;
      score_r    <= 12'd0;
      best_r     <= 12'd0;
      new_best_r <= 1'b0;
      game_rst_r <= 1'b0;
      waiting_r  <= 1'b1;
      playing_r  <= 1'b0;
      over_r     <= 1'b0;
      scan_en_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      btn_q_r    <= start_btn;
      hold_r     <= hold_nxt_s;
      scan_cnt_r <= scan_cnt_nxt_s;
      score_r    <= score_nxt_s;
      best_r     <= best_nxt_s;
      new_best_r <= new_best_nxt_s;
      game_rst_r <= game_rst_nxt_s;
      waiting_r  <= (state_nxt_s == ST_WAIT);
      playing_r  <= (state_nxt_s == ST_PLAY);
      over_r     <= (state_nxt_s == ST_OVER);
      scan_en_r  <= scan_wrap_s;
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed game scenarios plus random traffic, checked every
// cycle against a behavioural model of the game rules.
module tb_score_ctrl;

  localparam int SMAX = 10;
  localparam int HOLD = 4;
  localparam int SDIV = 5;
  localparam int PH_WAIT = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_OVER = 2;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b1;
  logic        pass_pulse = 1'b0;
  logic        collide = 1'b0;
  logic        waiting, playing, over, game_rst, new_best, scan_en;
  logic [11:0] score, best;

  int errors = 0;
  int checks = 0;

  // Model state: phase, numbers, and time stamps rather than counters.
  int  m_phase = PH_WAIT;
  int  m_score = 0;
  int  m_best = 0;
  bit  m_nb = 1'b0;
  bit  m_grst = 1'b0;
  bit  m_scan = 1'b0;
  bit  m_prev_btn = 1'b1;
  int  m_edge = 0;
  int  m_reset_edge = 0;
  int  m_over_edge = 0;
  bit  m_valid = 1'b0;

  score_ctrl #(.SCORE_MAX(SMAX), .HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
    .vga_clk(vga_clk), .rst(rst), .start_btn(start_btn),
    .pass_pulse(pass_pulse), .collide(collide),
    .waiting(waiting), .playing(playing), .over(over), .game_rst(game_rst),
    .score(score), .best(best), .new_best(new_best), .scan_en(scan_en)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: advances on every rising edge from the inputs applied during that cycle.
  initial begin
    bit rise;
    forever begin
      @(posedge vga_clk);
      m_edge++;
      if (rst) begin
        m_valid = 1'b1;
        m_phase = PH_WAIT; m_score = 0; m_best = 0; m_nb = 1'b0;
        m_grst = 1'b0; m_scan = 1'b0; m_prev_btn = 1'b1;
        m_reset_edge = m_edge;
      end else begin
        rise = start_btn && !m_prev_btn;
        m_prev_btn = start_btn;
        m_grst = 1'b0;
        m_scan = ((m_edge - m_reset_edge) % SDIV) == 0;
        if (m_phase == PH_WAIT) begin
          if (rise) begin
            m_phase = PH_PLAY; m_score = 0; m_grst = 1'b1;
          end
        end else if (m_phase == PH_PLAY) begin
          if (collide) begin
            if (m_score > m_best) begin
              m_best = m_score; m_nb = 1'b1;
            end
            m_phase = PH_OVER;
            m_over_edge = m_edge;
          end else if (pass_pulse) begin
            m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
          end
        end else begin
          if (rise && (m_edge - m_over_edge) >= HOLD) begin
            m_phase = PH_WAIT; m_nb = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge vga_clk);
      if (m_valid) begin
        chk("waiting",  int'(waiting),  int'(m_phase == PH_WAIT));
        chk("playing",  int'(playing),  int'(m_phase == PH_PLAY));
        chk("over",     int'(over),     int'(m_phase == PH_OVER));
        chk("game_rst", int'(game_rst), int'(m_grst));
        chk("score",    int'(score),    m_score);
        chk("best",     int'(best),     m_best);
        chk("new_best", int'(new_best), int'(m_nb));
        chk("scan_en",  int'(scan_en),  int'(m_scan));
      end
    end
  end

  task automatic tick(input bit r, input bit b, input bit p, input bit c);
    rst = r; start_btn = b; pass_pulse = p; collide = c;
    @(negedge vga_clk);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) tick(1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic press();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge vga_clk);
    // Reset with button held, keep it held: no game may start.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lit_reset_waiting", int'(waiting), 1);
    chk("lit_reset_score", int'(score), 0);
    idle(3, 1'b1);
    chk("lit_held_btn_waiting", int'(waiting), 1);
    idle(1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_start_playing", int'(playing), 1);
    chk("lit_start_game_rst", int'(game_rst), 1);
    idle(1, 1'b0);
    chk("lit_game_rst_drop", int'(game_rst), 0);
    // Game 1: seven passes, then collide with a simultaneous pass.
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lit_g1_over", int'(over), 1);
    chk("lit_g1_score", int'(score), 7);
    chk("lit_g1_best", int'(best), 7);
    chk("lit_g1_new_best", int'(new_best), 1);
    // Early press is dropped, later press returns to WAIT.
    idle(1, 1'b0);
    press();
    chk("lit_early_press_over", int'(over), 1);
    idle(3, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_exit_waiting", int'(waiting), 1);
    chk("lit_exit_new_best", int'(new_best), 0);
    chk("lit_exit_score", int'(score), 7);
    idle(2, 1'b0);
    // Game 2: three points, best unchanged.
    press();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_g2_best", int'(best), 7);
    chk("lit_g2_new_best", int'(new_best), 0);
    idle(5, 1'b0);
    press();
    // Game 3: fifteen passes saturate at SCORE_MAX.
    press();
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lit_g3_saturate", int'(score), SMAX);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_g3_best", int'(best), SMAX);
    chk("lit_g3_new_best", int'(new_best), 1);
    idle(5, 1'b0);
    press();
    // Game 4: five points then reset mid-play.
    press();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_midrst_waiting", int'(waiting), 1);
    chk("lit_midrst_score", int'(score), 0);
    chk("lit_midrst_best", int'(best), 0);
    idle(20, 1'b0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(399) == 0), ($urandom_range(3) == 0),
           ($urandom_range(2) == 0), ($urandom_range(24) == 0));
    end
    idle(2, 1'b0);
    @(negedge vga_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
